frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 The block SHALL have parameter IMG_SIZE, default 32, meaning image width and height in pixels (square image).
REQ-002 The block SHALL have parameter CH_IN, default 3, meaning channels per pixel.
REQ-003 The block SHALL have parameter BW, default 16, meaning bits per channel.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port vld_in, input, 1 bit: an upstream pixel is present on in.
REQ-007 The block SHALL have port in, input, [CH_IN-1:0][BW-1:0]: upstream pixel, raster order.
REQ-008 The block SHALL have port rdy_in, output, 1 bit: the block can accept a pixel this cycle.
REQ-009 The block SHALL have port vld_out, output, 1 bit: a pixel is present on out, feeding the windower vld_in.
REQ-010 The block SHALL have port out, output, [CH_IN-1:0][BW-1:0]: the pixel sent downstream.
REQ-011 The block SHALL have port last_out, output, 1 bit: out carries the final pixel of a frame.

Function
REQ-012 Define N = IMG_SIZE*IMG_SIZE; a pixel SHALL be accepted on each rising edge where vld_in and rdy_in are both high; vld_in with rdy_in low SHALL be ignored.
REQ-013 rdy_in SHALL depend only on registered state, never combinationally on vld_in.
REQ-014 Accepted pixels SHALL be written sequentially into a frame bank of depth N; the bank becomes FULL on the edge that accepts pixel N-1.
REQ-015 The block SHALL have an FSM on the read side with states IDLE and STREAM.
REQ-016 FSM transitions: IDLE->STREAM when a FULL bank exists; STREAM->STREAM at end of frame if another bank is FULL; STREAM->IDLE at end of frame otherwise.
REQ-017 Once vld_out rises for a frame, it SHALL stay high for exactly N consecutive cycles, with no gaps; out SHALL present pixels 0..N-1 in acceptance order.
REQ-018 Latency: vld_out SHALL first assert on the second rising edge after the edge that fills the bank, when the read FSM is IDLE.
REQ-019 last_out SHALL be high only in the cycle carrying pixel N-1; vld_out low implies last_out low.
REQ-020 After pixel N-1 is read, its bank SHALL become EMPTY and writable on the following edge.
REQ-021 Back-to-back: if the next bank is FULL when pixel N-1 is sent, pixel 0 of that bank SHALL follow in the very next cycle, keeping vld_out high.
REQ-022 Gaps on vld_in SHALL never produce gaps on vld_out; upstream stalls only delay the frame start.
REQ-023 Bank selection SHALL alternate strictly (write and read pointers toggle per frame), so frames leave in arrival order.
REQ-024 A write and a read in the same cycle to different banks SHALL both complete.

Reset
REQ-025 While reset is high, vld_out, last_out and out SHALL be 0, the FSM SHALL be IDLE, all banks EMPTY, and all counters and bank pointers 0.
REQ-026 In the first cycle after reset deasserts, rdy_in SHALL be 1.
REQ-027 Reset asserted mid-frame, on either the write or read side, SHALL discard all buffered pixels; the next accepted pixel is pixel 0 of bank 0.
REQ-028 Bank storage contents need not be reset.

Configuration
REQ-029 With the macro FRAME_STREAMER_DOUBLE_BUF_EN defined, there SHALL be two banks (ping-pong), and rdy_in SHALL be high whenever the current write bank is not FULL.
REQ-030 Without FRAME_STREAMER_DOUBLE_BUF_EN, there SHALL be one bank; rdy_in SHALL be low from the bank-FULL edge until the edge after pixel N-1 is sent; REQ-021 then never applies.

Verification
REQ-031 With IMG_SIZE=4, CH_IN=2, BW=8, feed pixels 0..15 with vld_in always high -> vld_out rises 2 edges after the 16th accept, stays high 16 cycles, out = 0..15, last_out high only on 15.
REQ-032 Same setup, vld_in randomly low 50% of the time -> output burst is still 16 contiguous cycles with identical data.
REQ-033 DOUBLE_BUF_EN defined, two frames streamed continuously -> 32 contiguous vld_out cycles, rdy_in never low once streaming starts.
REQ-034 DOUBLE_BUF_EN undefined, continuous input -> rdy_in is low for exactly 18 cycles per frame (FULL edge through read-done edge); frames are separated by a gap on vld_out.
REQ-035 Reset asserted at output pixel 7 -> vld_out and last_out drop immediately; new pixels 100..115 emerge as a clean frame with no stale data.
REQ-036 vld_in held high while rdy_in is low -> no extra pixels stored; the frame count and data match the accepted pixels only.

Source files
------------

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - frame buffer that turns a stalling pixel stream into gap-free frames
//
// Purpose: collects IMG_SIZE*IMG_SIZE pixels into a frame bank, then replays
// the whole frame downstream as one contiguous burst.
// Macro FRAME_STREAMER_DOUBLE_BUF_EN: two ping-pong banks instead of one.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-high reset
//   vld_in   - upstream pixel present on in
//   in       - upstream pixel, raster order
//   rdy_in   - block accepts a pixel this cycle (registered state only)
//   vld_out  - pixel present on out
//   out      - downstream pixel
//   last_out - out carries the final pixel of a frame
module frame_streamer #(
    parameter int IMG_SIZE = 32,
    parameter int CH_IN    = 3,
    parameter int BW       = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      vld_in,
    input  logic [CH_IN-1:0][BW-1:0]  in,
    output logic                      rdy_in,
    output logic                      vld_out,
    output logic [CH_IN-1:0][BW-1:0]  out,
    output logic                      last_out
);

    localparam int N  = IMG_SIZE * IMG_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = CH_IN * BW;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef FRAME_STREAMER_DOUBLE_BUF_EN
    localparam bit DB = 1'b1;
    localparam int AW = CW + 1;
`else
    localparam bit DB = 1'b0;
    localparam int AW = CW;
`endif

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      full_q, full_d;
    logic            out_bank_q;
    logic [PW-1:0]   out_q;
    logic            vld_q, last_q;
    logic            wr_en, rd_en;
    logic [1:0]      drain_mask, avail;
    logic [AW-1:0]   wr_addr, rd_addr;

    logic [PW-1:0]   mem [2**AW];

`ifdef FRAME_STREAMER_DOUBLE_BUF_EN
    assign wr_addr = {wr_ptr_q, wr_cnt_q};
    assign rd_addr = {rd_ptr_q, rd_cnt_q};
`else
    assign wr_addr = wr_cnt_q;
    assign rd_addr = rd_cnt_q;
`endif

    assign rdy_in   = ~full_q[wr_ptr_q];
    assign wr_en    = vld_in & rdy_in;
    assign vld_out  = vld_q;
    assign last_out = last_q;
    assign out      = out_q;

    // A bank whose final pixel is on the output this cycle is still marked
    // FULL until the next edge; it must not be picked up for another read.
    assign drain_mask = last_q ? (2'b01 << out_bank_q) : 2'b00;
    assign avail      = full_q & ~drain_mask;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        if (wr_en) begin
            if (wr_cnt_q == LAST) begin
                wr_cnt_d         = '0;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = DB ? ~wr_ptr_q : wr_ptr_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        // Set and clear never hit the same bank: a FULL bank is not writable.
        if (last_q) begin
            full_d[out_bank_q] = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_ptr_d = rd_ptr_q;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (avail[rd_ptr_q]) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                end
            end
            STREAM: begin
                rd_en = 1'b1;
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = '0;
                    rd_ptr_d = DB ? ~rd_ptr_q : rd_ptr_q;
                    // Back-to-back only when the other bank is already FULL.
                    if (DB && avail[~rd_ptr_q]) begin
                        state_d = STREAM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            full_q     <= 2'b00;
            out_bank_q <= 1'b0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            if (rd_en) begin
                out_q      <= mem[rd_addr];
                vld_q      <= 1'b1;
                last_q     <= (rd_cnt_q == LAST);
                out_bank_q <= rd_ptr_q;
            end else begin
                out_q  <= '0;
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end
        end
    end

    // Pixel storage carries no reset; FULL flags alone decide what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= in;
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// tb/tb_frame_streamer.sv - directed self-checking bench for frame_streamer
module tb_frame_streamer;

    localparam int IMG = 4;
    localparam int CH  = 2;
    localparam int BWD = 8;
    localparam int N   = IMG * IMG;

`ifdef FRAME_STREAMER_DOUBLE_BUF_EN
    localparam int EXP_RDY_LOW = 0;
`else
    localparam int EXP_RDY_LOW = 18;
`endif

    logic                   clk;
    logic                   rst;
    logic                   vld_in;
    logic [CH-1:0][BWD-1:0] din;
    logic                   rdy_in;
    logic                   vld_out;
    logic [CH-1:0][BWD-1:0] dout;
    logic                   last_out;

    int cyc;
    int checks;
    int errors;
    int la, rl, f1, f2, w, extra;

    frame_streamer #(
        .IMG_SIZE (IMG),
        .CH_IN    (CH),
        .BW       (BWD)
    ) dut (
        .clock    (clk),
        .reset    (rst),
        .vld_in   (vld_in),
        .in       (din),
        .rdy_in   (rdy_in),
        .vld_out  (vld_out),
        .out      (dout),
        .last_out (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [15:0] px(input int p);
        logic [7:0] a;
        a = p[7:0];
        return {a ^ 8'h5A, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers pixels base..base+count-1; last_acc is the cycle count read at
    // the falling edge just before the accepting rising edge.
    task automatic feed(input int base, input int count, input bit gaps,
                        output int last_acc, output int rdy_low);
        int i;
        int budget;
        i = 0;
        budget = 0;
        rdy_low = 0;
        last_acc = -1;
        while (i < count && budget < 3000) begin
            @(negedge clk);
            vld_in = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            din = px(base + i);
            if (!rdy_in) rdy_low++;
            if (vld_in && rdy_in) begin
                i++;
                last_acc = cyc;
            end
            budget++;
        end
        @(posedge clk);
        #1 vld_in = 1'b0;
        check("feed_done", i, count);
    endtask

    task automatic collect(input int base, output int first_cyc);
        int waited;
        waited = 0;
        first_cyc = -1;
        @(negedge clk);
        while (!vld_out && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("vld_start", vld_out, 1);
        if (vld_out) begin
            first_cyc = cyc;
            for (int i = 0; i < N; i++) begin
                if (i > 0) @(negedge clk);
                check("vld_burst", vld_out, 1);
                check("data", dout, px(base + i));
                check("last", last_out, (i == N - 1));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        vld_in = 1'b0;
        din    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vld", vld_out, 0);
        check("rst_last", last_out, 0);
        check("rst_out", dout, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", rdy_in, 1);

        // Continuous single frame, latency of two edges after the fill
        fork
            feed(0, N, 1'b0, la, rl);
            collect(0, f1);
        join
        check("latency_a", f1 - la, 3);

        // Random upstream gaps still give a contiguous burst
        fork
            feed(0, N, 1'b1, la, rl);
            collect(0, f1);
        join
        check("latency_b", f1 - la, 3);

        // Two frames offered continuously, vld_in held high through stalls
        fork
            feed(16, 2 * N, 1'b0, la, rl);
            begin
                collect(16, f1);
                collect(32, f2);
            end
        join
        check("rdy_low", rl, EXP_RDY_LOW);
`ifdef FRAME_STREAMER_DOUBLE_BUF_EN
        check("back_to_back", f2 - f1, N);
`else
        check("frame_gap", (f2 - f1 > N), 1);
        check("latency_c", f2 - la, 3);
`endif

        // Reset in the middle of the output burst
        fork
            feed(200, N, 1'b0, la, rl);
            begin
                w = 0;
                @(negedge clk);
                while (!vld_out && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                check("rd_rst_start", vld_out, 1);
                repeat (7) @(negedge clk);
                check("rd_rst_px7", dout, px(207));
                rst = 1'b1;
                #1;
                check("rd_rst_vld", vld_out, 0);
                check("rd_rst_last", last_out, 0);
                check("rd_rst_out", dout, 0);
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rd_rst_rdy", rdy_in, 1);

        // Reset in the middle of a frame write
        feed(50, 5, 1'b0, la, rl);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fork
            feed(100, N, 1'b0, la, rl);
            collect(100, f1);
        join
        check("latency_d", f1 - la, 3);

        // Nothing further may emerge
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (vld_out || last_out) extra++;
        end
        check("no_extra", extra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
